counter_cmd_sequencer: RTL

Command sequencer that sits directly upstream of the 16-bit up/down counter and drives its control inputs.
- Accepts LOAD/UP/DOWN/HOLD commands over a valid/ready handshake.
- Expands each command into cycle-exact ld_cnt, count_enb and updn_cnt patterns.
- Reports completion with a one-cycle done pulse.
- Observes the counter's data_out for the optional wrap guard.

---
 rtl/counter_seq_pkg.sv | 21 ++
 rtl/counter_cmd_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter command sequencer.
package counter_seq_pkg;

  localparam int CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_HOLD = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COUNT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer driving the up/down counter control inputs.
// Optional wrap guard: define COUNTER_SEQ_SAT_GUARD_EN to clamp UP/DOWN
// step counts to the counter headroom and report it on sat.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_LOAD  | one cycle with ld_cnt low, data_in = load value
// S_COUNT | count_enb high, rem cycles remaining (incl. this one)
// S_HOLD  | counter untouched, rem cycles remaining (incl. this one)
// S_DONE  | one-cycle done pulse with aborted/sat qualifiers
module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int OP_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_out,
  output logic             ld_cnt,
  output logic             count_enb,
  output logic             updn_cnt,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             sat
);

`ifdef COUNTER_SEQ_SAT_GUARD_EN
  localparam bit SAT_GUARD = 1'b1;
`else
  localparam bit SAT_GUARD = 1'b0;
`endif

  seq_state_e       state, state_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic             sat_pend, sat_pend_n;
  logic             ld_cnt_n, count_enb_n, updn_cnt_n;
  logic [WIDTH-1:0] data_in_n;
  logic             done_n, aborted_n, sat_n;
  logic [WIDTH-1:0] headroom;
  logic             clamp;
  cmd_op_e          op;

  assign op        = cmd_op_e'(cmd_op[1:0]);
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);

  // Headroom to the wrap point in the requested direction; only matters
  // when the guard is compiled in, otherwise clamp folds to zero.
  always_comb begin
    headroom = (op == OP_UP) ? ~data_out : data_out;
    clamp    = SAT_GUARD && (cmd_data > headroom);
  end

  // Next-state and next registered-output decode.
  always_comb begin
    state_n     = state;
    rem_n       = rem;
    sat_pend_n  = sat_pend;
    ld_cnt_n    = 1'b1;
    count_enb_n = 1'b0;
    updn_cnt_n  = updn_cnt;
    data_in_n   = data_in;
    done_n      = 1'b0;
    aborted_n   = 1'b0;
    sat_n       = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rem_n      = cmd_data;
          sat_pend_n = 1'b0;
          case (op)
            OP_LOAD: begin
              state_n   = S_LOAD;
              ld_cnt_n  = 1'b0;
              data_in_n = cmd_data;
            end
            OP_UP, OP_DOWN: begin
              updn_cnt_n = (op == OP_UP);
              if (clamp) begin
                rem_n      = headroom;
                sat_pend_n = 1'b1;
              end
              if (rem_n == '0) begin
                state_n = S_DONE;
                done_n  = 1'b1;
                sat_n   = sat_pend_n;
              end else begin
                state_n     = S_COUNT;
                count_enb_n = 1'b1;
              end
            end
            default: begin
              if (cmd_data == '0) begin
                state_n = S_DONE;
                done_n  = 1'b1;
              end else begin
                state_n = S_HOLD;
              end
            end
          endcase
        end
      end
      S_LOAD: begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
      S_COUNT, S_HOLD: begin
        rem_n = rem - WIDTH'(1);
        if (rem == WIDTH'(1)) begin
          // Last cycle: normal completion takes precedence over abort.
          state_n = S_DONE;
          done_n  = 1'b1;
          sat_n   = sat_pend;
        end else if (abort) begin
          state_n   = S_DONE;
          done_n    = 1'b1;
          aborted_n = 1'b1;
          sat_n     = sat_pend;
        end else begin
          count_enb_n = (state == S_COUNT);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, step counter and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rem       <= '0;
      sat_pend  <= 1'b0;
      ld_cnt    <= 1'b1;
      count_enb <= 1'b0;
      updn_cnt  <= 1'b0;
      data_in   <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      sat_pend  <= sat_pend_n;
      ld_cnt    <= ld_cnt_n;
      count_enb <= count_enb_n;
      updn_cnt  <= updn_cnt_n;
      data_in   <= data_in_n;
      done      <= done_n;
      aborted   <= aborted_n;
      sat       <= sat_n;
    end
  end

endmodule
